// File: rtl/rr_arbiter_idx_pkg.sv
// Shared definitions for the round-robin arbiter family.
//
// Contents:
//   arb_state_e : IDLE/LOCKED state encoding. The encoding is shared so that
//                 other arbiters with a hold/lock mode decode state the same way.
package rr_arbiter_idx_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter_idx_oh_encoder.sv
// One-hot to binary encoder, fully parametrised.
//
// Ports:
//   oh  : OH_WIDTH-bit one-hot input (at most one bit set)
//   idx : IDX_WIDTH-bit binary index of the set bit; 0 when oh is all zero
//
// Each set bit ORs its own index into the result, so the width of the term
// list scales with OH_WIDTH rather than being written out by hand.
module oh_encoder #(
  parameter int OH_WIDTH  = 4,
  parameter int IDX_WIDTH = $clog2(OH_WIDTH)
) (
  input  logic [OH_WIDTH-1:0]  oh,
  output logic [IDX_WIDTH-1:0] idx
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < OH_WIDTH; i++) begin
      if (oh[i]) begin
        idx = idx | IDX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_idx.sv
// Round-robin arbiter with binary grant index and a lock (hold) mode.
//
// Ports:
//   clk         : clock, all state on the rising edge
//   reset_n     : asynchronous active-low reset
//   request     : NUM_REQUESTERS level-sensitive request lines
//   update      : consumer accepted this cycle's grant
//   hold        : with update=1, lock the current grantee
//   grant_oh    : one-hot grant (combinational)
//   grant_idx   : binary index of grant_oh, 0 when no grant
//   grant_valid : 1 iff grant_oh is non-zero
//   locked      : registered, 1 while the arbiter is in the LOCKED state
//
// Handshake: grant_valid/grant_oh act as a "valid" offered this cycle and
// update acts as "ready". A transfer happens on a rising edge where both
// grant_valid and update are 1; only then does priority advance (hold=0) or
// the grantee become the lock owner (hold=1). update with no grant is ignored.
// While locked, the owner keeps the grant until it accepts with hold=0 or
// drops its request; the freed priority starts just after the owner.
module rr_arbiter_idx
  import rr_arbiter_idx_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int IDX_WIDTH      = $clog2(NUM_REQUESTERS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic                      update,
  input  logic                      hold,
  output logic [NUM_REQUESTERS-1:0] grant_oh,
  output logic [IDX_WIDTH-1:0]      grant_idx,
  output logic                      grant_valid,
  output logic                      locked
);

  localparam int DBL = 2 * NUM_REQUESTERS;

  arb_state_e                 state, state_n;
  logic [IDX_WIDTH-1:0]       ptr, ptr_n;
  logic [IDX_WIDTH-1:0]       owner, owner_n;

  logic [DBL-1:0]             req_dbl;
  logic [DBL-1:0]             masked;
  logic [DBL-1:0]             pick_dbl;
  logic [NUM_REQUESTERS-1:0]  rr_oh;
  logic [NUM_REQUESTERS-1:0]  owner_oh;

  // Increment with explicit wrap at NUM_REQUESTERS-1, so non-power-of-2
  // sizes never leave ptr/owner pointing past the last requester.
  function automatic logic [IDX_WIDTH-1:0] wrap_inc(input logic [IDX_WIDTH-1:0] v);
    if (v == IDX_WIDTH'(NUM_REQUESTERS - 1)) begin
      return '0;
    end
    return v + IDX_WIDTH'(1);
  endfunction

  // Round-robin search: duplicate the request vector, clear bits below ptr in
  // the lower copy, isolate the lowest set bit, then fold the two halves.
  // The upper copy is never masked, so wrap-around requests are still found.
  always_comb begin
    req_dbl  = {request, request};
    masked   = req_dbl & ({DBL{1'b1}} << ptr);
    pick_dbl = masked & (~masked + DBL'(1));
    rr_oh    = pick_dbl[NUM_REQUESTERS-1:0] | pick_dbl[DBL-1:NUM_REQUESTERS];
  end

  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = request[owner];
  end

  assign grant_oh    = (state == ARB_LOCKED) ? owner_oh : rr_oh;
  assign grant_valid = |grant_oh;
  assign locked      = (state == ARB_LOCKED);

  oh_encoder #(
    .OH_WIDTH  (NUM_REQUESTERS),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_enc (
    .oh  (grant_oh),
    .idx (grant_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ARB_IDLE;
      ptr   <= '0;
      owner <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      owner <= owner_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    case (state)
      ARB_IDLE: begin
        if (update && grant_valid) begin
          if (hold) begin
            owner_n = grant_idx;
            state_n = ARB_LOCKED;
          end else begin
            ptr_n = wrap_inc(grant_idx);
          end
        end
      end
      ARB_LOCKED: begin
        // Release when the owner lets go of its request or accepts without hold.
        if (!request[owner] || (update && !hold)) begin
          ptr_n   = wrap_inc(owner);
          state_n = ARB_IDLE;
        end
      end
      default: begin
        state_n = ARB_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_arbiter_idx.sv
// Bench for rr_arbiter_idx: one 4-requester and one 5-requester instance,
// directed scenarios followed by randomized traffic, both compared against a
// behavioural model (modulo search over requesters, integer ptr/owner).
module tb_rr_arbiter_idx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;

  logic [3:0] request4 = '0;
  logic       update4 = 1'b0, hold4 = 1'b0;
  logic [3:0] grant_oh4;
  logic [1:0] grant_idx4;
  logic       grant_valid4, locked4;

  logic [4:0] request5 = '0;
  logic       update5 = 1'b0, hold5 = 1'b0;
  logic [4:0] grant_oh5;
  logic [2:0] grant_idx5;
  logic       grant_valid5, locked5;

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  int m4_ptr = 0, m4_own = 0;
  bit m4_lk = 1'b0;
  int m5_ptr = 0, m5_own = 0;
  bit m5_lk = 1'b0;

  rr_arbiter_idx #(.NUM_REQUESTERS(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .request(request4), .update(update4), .hold(hold4),
    .grant_oh(grant_oh4), .grant_idx(grant_idx4), .grant_valid(grant_valid4), .locked(locked4)
  );

  rr_arbiter_idx #(.NUM_REQUESTERS(5)) dut5 (
    .clk(clk), .reset_n(reset_n), .request(request5), .update(update5), .hold(hold5),
    .grant_oh(grant_oh5), .grant_idx(grant_idx5), .grant_valid(grant_valid5), .locked(locked5)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Grantee index per the arbitration rules, or -1 when nothing is granted.
  function automatic int model_grant(input int n, input int ptr, input bit lk,
                                     input int own, input logic [7:0] req);
    if (lk) return req[own] ? own : -1;
    for (int k = 0; k < n; k++) begin
      if (req[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  task automatic model_adv(input int n, input logic [7:0] req, input logic u, input logic h,
                           inout int ptr, inout bit lk, inout int own);
    int g;
    g = model_grant(n, ptr, lk, own, req);
    if (!lk) begin
      if (u && g >= 0) begin
        if (h) begin
          own = g;
          lk  = 1'b1;
        end else begin
          ptr = (g + 1) % n;
        end
      end
    end else if (!req[own] || (u && !h)) begin
      ptr = (own + 1) % n;
      lk  = 1'b0;
    end
  endtask

  task automatic model_reset();
    m4_ptr = 0; m4_own = 0; m4_lk = 1'b0;
    m5_ptr = 0; m5_own = 0; m5_lk = 1'b0;
  endtask

  // driver tasks: called at a falling edge, outputs settle before the check
  task automatic drive(input logic [3:0] r4, input logic u4, input logic h4,
                       input logic [4:0] r5, input logic u5, input logic h5);
    request4 = r4; update4 = u4; hold4 = h4;
    request5 = r5; update5 = u5; hold5 = h5;
    #2;
  endtask

  task automatic d4(input logic [3:0] r, input logic u, input logic h);
    drive(r, u, h, 5'b0, 1'b0, 1'b0);
  endtask

  task automatic d5(input logic [4:0] r, input logic u, input logic h);
    drive(4'b0, 1'b0, 1'b0, r, u, h);
  endtask

  // scoreboard: compare all outputs of both instances against the model
  task automatic check_model();
    int e;
    e = model_grant(4, m4_ptr, m4_lk, m4_own, 8'(request4));
    chk("valid4", 32'(grant_valid4), 32'(e >= 0));
    chk("idx4",   32'(grant_idx4),   (e >= 0) ? 32'(e) : 32'd0);
    chk("oh4",    32'(grant_oh4),    (e >= 0) ? (32'd1 << e) : 32'd0);
    chk("locked4", 32'(locked4),     32'(m4_lk));
    e = model_grant(5, m5_ptr, m5_lk, m5_own, 8'(request5));
    chk("valid5", 32'(grant_valid5), 32'(e >= 0));
    chk("idx5",   32'(grant_idx5),   (e >= 0) ? 32'(e) : 32'd0);
    chk("oh5",    32'(grant_oh5),    (e >= 0) ? (32'd1 << e) : 32'd0);
    chk("locked5", 32'(locked5),     32'(m5_lk));
  endtask

  task automatic tick();
    @(posedge clk);
    model_adv(4, 8'(request4), update4, hold4, m4_ptr, m4_lk, m4_own);
    model_adv(5, 8'(request5), update5, hold5, m5_ptr, m5_lk, m5_own);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(4'b0, 1'b0, 1'b0, 5'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_locked4", 32'(locked4), 32'd0);
    chk("rst_locked5", 32'(locked5), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Fairness: all requests, accept every cycle
    for (int i = 0; i < 8; i++) begin
      d4(4'b1111, 1'b1, 1'b0);
      check_model();
      chk("fair_idx", 32'(grant_idx4), 32'(i % 4));
      chk("fair_valid", 32'(grant_valid4), 32'd1);
      tick();
    end

    // Sparse requests 1010; ptr moves to 2 after the first accept
    do_reset();
    d4(4'b1010, 1'b1, 1'b0); check_model(); chk("sparse_first", 32'(grant_idx4), 32'd1); tick();
    d4(4'b1111, 1'b0, 1'b0); check_model(); chk("ptr_is_2", 32'(grant_idx4), 32'd2); tick();
    d4(4'b0000, 1'b1, 1'b0); check_model(); chk("noreq_valid", 32'(grant_valid4), 32'd0); tick();
    d4(4'b1111, 1'b0, 1'b0); check_model(); chk("noreq_ptr_kept", 32'(grant_idx4), 32'd2); tick();
    d4(4'b1010, 1'b1, 1'b0); check_model(); chk("sparse_2", 32'(grant_idx4), 32'd3); tick();
    d4(4'b1010, 1'b1, 1'b0); check_model(); chk("sparse_3", 32'(grant_idx4), 32'd1); tick();
    d4(4'b1010, 1'b1, 1'b0); check_model(); chk("sparse_4", 32'(grant_idx4), 32'd3); tick();

    // Non-power-of-2 wrap
    do_reset();
    d5(5'b10000, 1'b1, 1'b0); check_model(); chk("n5_last", 32'(grant_idx5), 32'd4); tick();
    d5(5'b00011, 1'b1, 1'b0); check_model(); chk("n5_wrap", 32'(grant_idx5), 32'd0); tick();

    // Lock and explicit release
    do_reset();
    d4(4'b0110, 1'b1, 1'b1); check_model(); chk("lock_take", 32'(grant_idx4), 32'd1); tick();
    for (int i = 0; i < 3; i++) begin
      d4(4'b1111, 1'b0, 1'b0); check_model();
      chk("lock_oh", 32'(grant_oh4), 32'b0010);
      chk("lock_flag", 32'(locked4), 32'd1);
      tick();
    end
    d4(4'b1111, 1'b1, 1'b0); check_model(); chk("release_cycle_oh", 32'(grant_oh4), 32'b0010); tick();
    d4(4'b1111, 1'b0, 1'b0); check_model();
    chk("released", 32'(locked4), 32'd0);
    chk("after_release", 32'(grant_idx4), 32'd2);
    tick();

    // Owner drops its request while locked
    d4(4'b0100, 1'b1, 1'b1); check_model(); chk("lock2", 32'(grant_idx4), 32'd2); tick();
    d4(4'b1001, 1'b0, 1'b0); check_model(); chk("drop_valid", 32'(grant_valid4), 32'd0); tick();
    d4(4'b1001, 1'b0, 1'b0); check_model();
    chk("drop_unlock", 32'(locked4), 32'd0);
    chk("drop_idx", 32'(grant_idx4), 32'd3);
    tick();

    // Asynchronous reset in the middle of a lock
    d4(4'b1000, 1'b1, 1'b1); check_model(); tick();
    d4(4'b1111, 1'b0, 1'b0); check_model(); chk("lock3_oh", 32'(grant_oh4), 32'b1000);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_unlock", 32'(locked4), 32'd0);
    check_model();
    chk("reset_ptr0", 32'(grant_idx4), 32'd0);
    reset_n = 1'b1;
    tick();
    d4(4'b1111, 1'b0, 1'b0); check_model(); chk("post_reset_idx", 32'(grant_idx4), 32'd0); tick();

    // Randomized traffic on both instances
    for (int i = 0; i < 600; i++) begin
      logic [3:0] r4;
      logic [4:0] r5;
      r4 = ($urandom_range(0, 5) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
      r5 = ($urandom_range(0, 5) == 0) ? 5'b0 : 5'($urandom_range(0, 31));
      drive(r4, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
            r5, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
      check_model();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_idx.md
Name: rr_arbiter_idx

Overview:
- Parametrised round-robin arbiter. Takes N request lines and produces three outputs: a one-hot grant, its binary index, and a valid flag.
- Adds a lock (hold) mode so a multi-cycle requester keeps ownership until it releases.
- Shared arbitration primitive for thread select, L2 request muxing and writeback port arbitration.
- Encodes the grant index internally, so clients need no separate one-hot decoder.

Parameters:
- NUM_REQUESTERS, 4, number of request lines; any value >= 2, including non-powers of 2.
- IDX_WIDTH, $clog2(NUM_REQUESTERS), width of the grant index.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- request  input  NUM_REQUESTERS  per-requester request, level-sensitive.
- update  input  1  consumer accepted this cycle's grant; advances priority or sets the lock.
- hold  input  1  sampled only when update=1; 1 locks the current grantee.
- grant_oh  output  NUM_REQUESTERS  one-hot grant, combinational from request and state.
- grant_idx  output  IDX_WIDTH  binary index of grant_oh; 0 when no grant.
- grant_valid  output  1  asserted iff grant_oh is non-zero.
- locked  output  1  registered; 1 while in LOCKED state.

Behaviour:
- State registers:
  - priority pointer ptr, IDX_WIDTH bits, range 0..NUM_REQUESTERS-1.
  - FSM state: IDLE or LOCKED.
  - owner index owner, IDX_WIDTH bits.
- Reset (async, reset_n=0): ptr=0, state=IDLE, owner=0, locked=0. Combinational outputs follow from request with ptr=0.
- IDLE grant:
  - Grant the first i with request[i]=1, searching ptr, ptr+1, … wrapping modulo NUM_REQUESTERS.
  - No request: grant_oh=0, grant_idx=0, grant_valid=0.
- LOCKED grant:
  - grant_oh = one-hot(owner) if request[owner]=1, else 0.
  - Other requests are ignored.
- Zero latency: a request asserted in cycle t is granted in cycle t.
- IDLE transitions, on a clock edge:
  - update=1, grant_valid=1, hold=0 -> ptr = grant_idx+1, with NUM_REQUESTERS-1 wrapping to 0; stay IDLE.
  - update=1, grant_valid=1, hold=1 -> owner=grant_idx; go to LOCKED; ptr unchanged.
  - update=1, grant_valid=0 -> no state change; update is ignored.
  - update=0 -> no change. Grant may move between cycles as request changes.
- LOCKED transitions:
  - update=1, hold=0, request[owner]=1 -> release: ptr = owner+1 (wrapped); go to IDLE.
  - request[owner]=0, regardless of update -> release: ptr = owner+1 (wrapped); go to IDLE.
  - Otherwise stay LOCKED. update=1 with hold=1 keeps the lock.
- Release cycle: grant is still owner (or none if owner dropped its request). The new arbitration takes effect the next cycle.
- Wrap: ptr never holds a value >= NUM_REQUESTERS. Increment compares against NUM_REQUESTERS-1, not a power-of-2 overflow.
- Fairness: with all requests held high and update=1 every cycle, the grant sequence is 0,1,…,N-1,0,…
- Invariants: grant_oh always has at most one bit set, and grant_idx always matches grant_oh.
- Reset mid-lock: locked drops immediately (asynchronous). The next cycle arbitrates from ptr=0.
- No X propagation: outputs are defined for any request value once reset has been applied.

Decomposition:
- Shared package (defaults.svh / shared defines): the IDLE/LOCKED state encoding as a localparam typedef, reused by other arbiters.
- Sub-module oh_encoder (parameters OH_WIDTH, IDX_WIDTH): fully parametrised one-hot to binary. It ORs masked indices in a loop over OH_WIDTH, with no fixed-width term list. rr_arbiter_idx instantiates it to derive grant_idx from grant_oh.
- Rotate/search logic stays in rr_arbiter_idx. It is implemented as a double-width priority pick (request concatenated with itself, masked at ptr) folded back to N bits.

Test Plan:
- Reset, then request=4'b1111 with update=1 for 8 cycles -> grant_idx 0,1,2,3,0,1,2,3; grant_valid=1 throughout.
- Reset, request=4'b1010 held, update=1 every cycle -> grant_idx 1,3,1,3; ptr after the first update = 2.
- NUM_REQUESTERS=5, request=5'b10000 with update=1 -> grant_idx=4, and ptr wraps to 0. Then request=5'b00011 -> grant_idx=0.
- Lock:
  - request=4'b0110 with update=1, hold=1 -> owner=1, locked=1.
  - Next 3 cycles with request=4'b1111 -> grant_oh=4'b0010 each cycle.
  - update=1, hold=0 -> locked=0. Next cycle grant_idx=2.
- Owner drop: locked with owner=2, request changes to 4'b1001 -> grant_valid=0 that cycle; next cycle locked=0, grant_idx=3 (ptr=3).
- reset_n pulsed low mid-LOCKED with owner=3 -> locked=0 asynchronously. After release, request=4'b1111 gives grant_idx=0.
- Throughout all scenarios, check update with request=0 leaves ptr unchanged.
